// File: rtl/core_controller_multi_axi_if.sv
// AXI4-Lite bus bundle between the PS interconnect (master) and the core controller (slave).
interface core_controller_multi_axi_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/core_controller_multi_axi.sv
// AXI4-Lite register block driving reset, exec, memory base and cycle counters for an array
// of compute cores, with per-core completion interrupts (enable + write-1-to-clear status).
module core_controller_multi_axi #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 16,
  parameter int NUM_CORES          = 4,
  parameter int STAT_WIDTH         = 8,
  parameter int DONE_BIT           = 0
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARSTN,
  core_controller_multi_axi_if.slave      axi,
  output logic [NUM_CORES-1:0]            CRST,
  output logic [NUM_CORES-1:0]            CEXEC,
  output logic [NUM_CORES*32-1:0]         CMEM_ADDR,
  input  logic [NUM_CORES*STAT_WIDTH-1:0] CSTAT,
  output logic                            IRQ
);
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = STAT_WIDTH;

  logic [31:0]          mem_q   [NUM_CORES];
  logic [31:0]          cycle_q [NUM_CORES];
  logic [NUM_CORES-1:0] irq_en, irq_stat, done_q, done_now, done_rise, stat_w1c;
  logic                 wr_fire, rd_fire, w_ok, r_ok;
  int                   w_page, r_page;
  logic [1:0]           w_reg, r_reg;
  logic [DW-1:0]        wmask, rd_word, en_merged;
  logic                 unused_ok;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] data,
                                          input logic [DW-1:0] mask);
    return (old & ~mask) | (data & mask);
  endfunction

  // Page 0 holds the global registers, page c+1 holds core c; word 3 of page 0 is a hole.
  always_comb begin
    wmask     = {{8{axi.wstrb[3]}}, {8{axi.wstrb[2]}}, {8{axi.wstrb[1]}}, {8{axi.wstrb[0]}}};
    w_page    = int'(axi.awaddr[AW-1:4]);
    w_reg     = axi.awaddr[3:2];
    w_ok      = (w_page == 0) ? (w_reg != 2'd3) : (w_page <= NUM_CORES);
    r_page    = int'(axi.araddr[AW-1:4]);
    r_reg     = axi.araddr[3:2];
    r_ok      = (r_page == 0) ? (r_reg != 2'd3) : (r_page <= NUM_CORES);
    wr_fire   = axi.awready & axi.awvalid & axi.wvalid;
    rd_fire   = axi.arready & axi.arvalid;
    done_now  = '0;
    for (int c = 0; c < NUM_CORES; c++) done_now[c] = CSTAT[c*SW+DONE_BIT];
    done_rise = done_now & ~done_q;
    en_merged = merge(DW'(irq_en), axi.wdata, wmask);
    stat_w1c  = '0;
    if (wr_fire && w_page == 0 && w_reg == 2'd1)
      stat_w1c = axi.wdata[NUM_CORES-1:0] & wmask[NUM_CORES-1:0];
    rd_word = '0;
    if (r_page == 0) begin
      case (r_reg)
        2'd0:    rd_word = {16'h0, 8'h02, 8'(NUM_CORES)};
        2'd1:    rd_word = DW'(irq_stat);
        2'd2:    rd_word = DW'(irq_en);
        default: rd_word = '0;
      endcase
    end
    for (int c = 0; c < NUM_CORES; c++) begin
      if (r_page == c + 1) begin
        case (r_reg)
          2'd0: rd_word = {30'b0, CEXEC[c], CRST[c]};
          2'd1: rd_word = mem_q[c];
          2'd2: rd_word = DW'(CSTAT[c*SW +: SW]);
          2'd3: rd_word = cycle_q[c];
        endcase
      end
    end
  end

  // Handshakes: a transfer occurs on a rising edge where valid and ready are both high.
  // AWREADY/WREADY are raised together only when both valids are present and no B response
  // is pending; ARREADY only while no R response is pending. BVALID/RVALID and their payloads
  // hold until the matching BREADY/RREADY transfer.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARSTN) begin
    if (!S_AXI_ARSTN) begin
      axi.awready <= 1'b0;
      axi.wready  <= 1'b0;
      axi.bvalid  <= 1'b0;
      axi.bresp   <= 2'b00;
      axi.arready <= 1'b0;
      axi.rvalid  <= 1'b0;
      axi.rresp   <= 2'b00;
      axi.rdata   <= '0;
      CRST        <= '1;
      CEXEC       <= '0;
      irq_en      <= '0;
      irq_stat    <= '0;
      done_q      <= '0;
      IRQ         <= 1'b0;
      for (int c = 0; c < NUM_CORES; c++) begin
        mem_q[c]   <= '0;
        cycle_q[c] <= '0;
      end
    end else begin
      axi.awready <= ~axi.awready & axi.awvalid & axi.wvalid & ~axi.bvalid;
      axi.wready  <= ~axi.awready & axi.awvalid & axi.wvalid & ~axi.bvalid;
      if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
      if (wr_fire) begin
        axi.bvalid <= 1'b1;
        axi.bresp  <= w_ok ? 2'b00 : 2'b10;
      end
      axi.arready <= ~axi.arready & axi.arvalid & ~axi.rvalid;
      if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
      if (rd_fire) begin
        axi.rvalid <= 1'b1;
        axi.rdata  <= rd_word;
        axi.rresp  <= r_ok ? 2'b00 : 2'b10;
      end
      done_q <= done_now;
      if (wr_fire && w_page == 0 && w_reg == 2'd2) irq_en <= en_merged[NUM_CORES-1:0];
      // Hardware set beats a same-cycle software clear.
      irq_stat <= (irq_stat & ~stat_w1c) | (done_rise & CEXEC);
      IRQ      <= |(irq_stat & irq_en);
      for (int c = 0; c < NUM_CORES; c++) begin
        if (done_rise[c] && CEXEC[c]) CEXEC[c] <= 1'b0;
        if (CEXEC[c] && !CRST[c] && cycle_q[c] != '1) cycle_q[c] <= cycle_q[c] + 32'd1;
        // Later assignments override the completion clear, so the written EXEC value wins.
        if (wr_fire && w_page == c + 1) begin
          if (w_reg == 2'd0 && axi.wstrb[0]) begin
            CRST[c]  <= axi.wdata[0];
            CEXEC[c] <= axi.wdata[1];
            if (axi.wdata[1] && !CEXEC[c]) cycle_q[c] <= '0;
          end
          if (w_reg == 2'd1) mem_q[c] <= merge(mem_q[c], axi.wdata, wmask);
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_mem
    assign CMEM_ADDR[32*c +: 32] = mem_q[c];
  end

  assign unused_ok = ^{axi.awprot, axi.arprot, axi.awaddr[1:0], axi.araddr[1:0],
                       en_merged[DW-1:NUM_CORES]};
endmodule

// File: tb/tb_core_controller_multi_axi.sv
// Bench for the multi-core AXI4-Lite controller: directed register-map scenarios followed by
// randomized register traffic checked against a register-level reference model.
module tb_core_controller_multi_axi;
  localparam int NC  = 4;
  localparam int LIM = 50;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NC-1:0]   crst, cexec;
  logic [NC*32-1:0] cmem;
  logic [NC*8-1:0] cstat;
  logic            irq;

  core_controller_multi_axi_if axi ();

  core_controller_multi_axi #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(16), .NUM_CORES(NC), .STAT_WIDTH(8), .DONE_BIT(0)
  ) dut (
    .S_AXI_ACLK (clk),
    .S_AXI_ARSTN(rst_n),
    .axi        (axi),
    .CRST       (crst),
    .CEXEC      (cexec),
    .CMEM_ADDR  (cmem),
    .CSTAT      (cstat),
    .IRQ        (irq)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  // Register-level reference model.
  logic [31:0]   m_mem [NC];
  logic [NC-1:0] m_crst, m_exec, m_en, m_stat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 0; axi.wdata = '0; axi.wstrb = '0;
    axi.wvalid = 0; axi.bready = 0; axi.araddr = '0; axi.arprot = '0; axi.arvalid = 0;
    axi.rready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_crst = '1; m_exec = '0; m_en = '0; m_stat = '0;
    for (int c = 0; c < NC; c++) m_mem[c] = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int b_hold, input int done_core, output logic [1:0] resp);
    int n;
    axi.awaddr = addr; axi.wdata = data; axi.wstrb = strb; axi.awprot = 3'($urandom_range(0, 7));
    axi.awvalid = 1; axi.wvalid = 1; axi.bready = 0;
    n = 0;
    @(negedge clk);
    while (!axi.awready && n < LIM) begin @(negedge clk); n++; end
    check("awready", 32'(axi.awready), 32'd1);
    check("wready", 32'(axi.wready), 32'd1);
    if (done_core >= 0) cstat[done_core*8] = 1'b1;
    @(posedge clk); #1;
    axi.awvalid = 0; axi.wvalid = 0;
    n = 0;
    @(negedge clk);
    while (!axi.bvalid && n < LIM) begin @(negedge clk); n++; end
    check("bvalid", 32'(axi.bvalid), 32'd1);
    resp = axi.bresp;
    for (int i = 0; i < b_hold; i++) begin
      @(negedge clk);
      check("bvalid_hold", 32'(axi.bvalid), 32'd1);
      check("bresp_hold", 32'(axi.bresp), 32'(resp));
    end
    axi.bready = 1;
    @(posedge clk); #1;
    axi.bready = 0;
    check("bvalid_drop", 32'(axi.bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [15:0] addr, input int r_hold,
                          output logic [31:0] data, output logic [1:0] resp);
    int n;
    axi.araddr = addr; axi.arprot = 3'($urandom_range(0, 7)); axi.arvalid = 1; axi.rready = 0;
    n = 0;
    @(negedge clk);
    while (!axi.arready && n < LIM) begin @(negedge clk); n++; end
    check("arready", 32'(axi.arready), 32'd1);
    @(posedge clk); #1;
    axi.arvalid = 0;
    n = 0;
    @(negedge clk);
    while (!axi.rvalid && n < LIM) begin @(negedge clk); n++; end
    check("rvalid", 32'(axi.rvalid), 32'd1);
    data = axi.rdata;
    resp = axi.rresp;
    for (int i = 0; i < r_hold; i++) begin
      @(negedge clk);
      check("rvalid_hold", 32'(axi.rvalid), 32'd1);
      check("rdata_hold", axi.rdata, data);
    end
    axi.rready = 1;
    @(posedge clk); #1;
    axi.rready = 0;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic model_write(input logic [15:0] addr, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
    logic [15:0] a;
    logic [31:0] byte_mask;
    int c, off;
    a = addr & 16'hFFFC;
    resp = 2'b00;
    byte_mask = bmerge(32'h0, 32'hFFFF_FFFF, s);
    if (a == 16'h0000) begin
    end else if (a == 16'h0004) begin
      m_stat = m_stat & ~NC'(d & byte_mask);
    end else if (a == 16'h0008) begin
      m_en = NC'(bmerge(32'(m_en), d, s));
    end else if (a >= 16'h0010 && a < 16'h0010 + 16'(16 * NC)) begin
      c = (int'(a) - 16) / 16;
      off = int'(a) % 16;
      if (off == 0 && s[0]) begin
        m_crst[c] = d[0];
        m_exec[c] = d[1];
      end else if (off == 4) begin
        m_mem[c] = bmerge(m_mem[c], d, s);
      end
    end else begin
      resp = 2'b10;
    end
  endtask

  task automatic model_read(input logic [15:0] addr, output logic [31:0] d, output logic [1:0] resp);
    logic [15:0] a;
    int c, off;
    a = addr & 16'hFFFC;
    resp = 2'b00;
    d = '0;
    if (a == 16'h0000) d = {16'h0, 8'h02, 8'(NC)};
    else if (a == 16'h0004) d = 32'(m_stat);
    else if (a == 16'h0008) d = 32'(m_en);
    else if (a >= 16'h0010 && a < 16'h0010 + 16'(16 * NC) && (int'(a) % 16) != 12) begin
      c = (int'(a) - 16) / 16;
      off = int'(a) % 16;
      if (off == 0) d = {30'b0, m_exec[c], m_crst[c]};
      else if (off == 4) d = m_mem[c];
      else d = 32'(cstat[c*8 +: 8]);
    end else resp = 2'b10;
  endtask

  // ---------------- stimulus and scoreboard ----------------
  initial begin
    logic [31:0] rd, ed;
    logic [1:0]  rsp, ersp;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [3:0]  ws;
    int          kind;

    cstat = '0;
    apply_reset();
    check("rst_crst", 32'(crst), 32'hF);
    check("rst_cexec", 32'(cexec), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_cmem", cmem[31:0] | cmem[63:32] | cmem[95:64] | cmem[127:96], 32'h0);
    axi_read(16'h0000, 0, rd, rsp);  check("version", rd, 32'h0000_0204);
    axi_read(16'h0010, 0, rd, rsp);  check("ctrl0_rst", rd, 32'h1);
    axi_read(16'h0008, 0, rd, rsp);  check("irq_en_rst", rd, 32'h0);

    // Byte strobes on core2 memory base.
    axi_write(16'h0034, 32'hDEAD_BEEF, 4'b0011, 0, -1, rsp);
    check("mem_bresp", 32'(rsp), 32'h0);
    axi_read(16'h0034, 0, rd, rsp);  check("mem_strb", rd, 32'h0000_BEEF);
    check("cmem2", cmem[95:64], 32'h0000_BEEF);

    // Completion on core1: counter runs from the CTRL write until the done edge.
    axi_write(16'h0008, 32'h2, 4'hF, 0, -1, rsp);
    axi_write(16'h0020, 32'h2, 4'hF, 0, -1, rsp);
    check("cexec1_on", 32'(cexec), 32'h2);
    check("crst1_off", 32'(crst[1]), 32'h0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    cstat[8] = 1'b1;
    repeat (2) @(negedge clk);
    check("cexec1_done", 32'(cexec), 32'h0);
    check("irq_set", 32'(irq), 32'h1);
    axi_read(16'h0004, 0, rd, rsp);  check("irq_stat_set", rd, 32'h2);
    // One count on the write's response edge, ten idle edges, one on the done edge.
    axi_read(16'h002C, 0, rd, rsp);  check("cycle1", rd, 32'd12);
    cstat[8] = 1'b0;
    repeat (3) @(posedge clk);
    axi_read(16'h002C, 0, rd, rsp);  check("cycle1_hold", rd, 32'd12);

    // W1C: a disabled byte lane clears nothing; an enabled one clears.
    axi_write(16'h0004, 32'h2, 4'b1110, 0, -1, rsp);
    axi_read(16'h0004, 0, rd, rsp);  check("w1c_no_strb", rd, 32'h2);
    axi_write(16'h0004, 32'h2, 4'hF, 0, -1, rsp);
    check("irq_cleared", 32'(irq), 32'h0);
    axi_read(16'h0004, 0, rd, rsp);  check("w1c_clear", rd, 32'h0);

    // W1C coinciding with a fresh done edge: the set wins.
    axi_write(16'h0020, 32'h2, 4'hF, 0, -1, rsp);
    axi_write(16'h0004, 32'h2, 4'hF, 0, 1, rsp);
    check("coinc_cexec", 32'(cexec[1]), 32'h0);
    axi_read(16'h0004, 0, rd, rsp);  check("coinc_stat", rd, 32'h2);
    check("coinc_irq", 32'(irq), 32'h1);
    cstat[8] = 1'b0;

    // Unmapped accesses.
    axi_read(16'h0100, 0, rd, rsp);
    check("unmap_rdata", rd, 32'h0);
    check("unmap_rresp", 32'(rsp), 32'h2);
    axi_write(16'h0100, 32'hFFFF_FFFF, 4'hF, 0, -1, rsp);
    check("unmap_bresp", 32'(rsp), 32'h2);
    axi_write(16'h000C, 32'hFFFF_FFFF, 4'hF, 0, -1, rsp);
    check("hole_bresp", 32'(rsp), 32'h2);
    axi_read(16'h0050, 0, rd, rsp);  check("page5_rresp", 32'(rsp), 32'h2);
    axi_read(16'h0034, 0, rd, rsp);  check("unmap_nochange", rd, 32'h0000_BEEF);
    axi_read(16'h0008, 0, rd, rsp);  check("unmap_en_nochange", rd, 32'h2);
    axi_write(16'h0018, 32'hFFFF_FFFF, 4'hF, 0, -1, rsp);
    check("ro_bresp", 32'(rsp), 32'h0);

    // Back-pressure on both response channels.
    axi_read(16'h0034, 5, rd, rsp);  check("hold_rdata", rd, 32'h0000_BEEF);
    axi_write(16'h0024, 32'h1234_5678, 4'hF, 5, -1, rsp);
    check("hold_cmem1", cmem[63:32], 32'h1234_5678);

    // Reset in the middle of a read with RVALID pending.
    axi.araddr = 16'h0034; axi.arvalid = 1; axi.rready = 0;
    for (int n = 0; n < LIM && !axi.arready; n++) @(negedge clk);
    @(posedge clk); #1;
    axi.arvalid = 0;
    @(negedge clk);
    check("mid_rvalid", 32'(axi.rvalid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(axi.rvalid), 32'h0);
    check("mid_rst_rdata", axi.rdata, 32'h0);
    check("mid_rst_crst", 32'(crst), 32'hF);
    check("mid_rst_cmem", cmem[63:32] | cmem[95:64], 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);

    // Randomized register traffic against the model.
    for (int c = 0; c < NC; c++) cstat[c*8 +: 8] = 8'($urandom_range(0, 255)) & 8'hFE;
    apply_reset();
    for (int it = 0; it < 80; it++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0: addr = 16'h0000;
        1: addr = 16'h0004;
        2: addr = 16'h0008;
        3: addr = 16'h000C;
        4: addr = ($urandom_range(0, 1) != 0) ? 16'h0100 : 16'h0050;
        default: addr = 16'h0010 + 16'(16 * $urandom_range(0, NC - 1)) + 16'(4 * $urandom_range(0, 2));
      endcase
      addr = addr | 16'($urandom_range(0, 3));
      if ($urandom_range(0, 1) != 0) begin
        wd = $urandom;
        ws = 4'($urandom_range(0, 15));
        model_write(addr, wd, ws, ersp);
        axi_write(addr, wd, ws, 0, -1, rsp);
        check("rnd_bresp", 32'(rsp), 32'(ersp));
        check("rnd_crst", 32'(crst), 32'(m_crst));
        check("rnd_cexec", 32'(cexec), 32'(m_exec));
        for (int c = 0; c < NC; c++) check("rnd_cmem", cmem[c*32 +: 32], m_mem[c]);
        check("rnd_irq", 32'(irq), 32'(|(m_stat & m_en)));
      end else begin
        model_read(addr, ed, ersp);
        exp_q.push_back(ed);
        axi_read(addr, 0, rd, rsp);
        check("rnd_rdata", rd, exp_q.pop_front());
        check("rnd_rresp", 32'(rsp), 32'(ersp));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
